// File: rtl/trace_pkg.sv
// Shared opcode/funct encodings, trace class codes and the retirement classifier
// for the instruction trace unit.
package trace_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_J     = 6'd2;

  localparam logic [5:0] FN_ADD  = 6'd32;
  localparam logic [5:0] FN_SUB  = 6'd34;
  localparam logic [5:0] FN_AND  = 6'd36;
  localparam logic [5:0] FN_OR   = 6'd37;
  localparam logic [5:0] FN_SRL  = 6'd2;
  localparam logic [5:0] FN_SLT  = 6'd42;
  localparam logic [5:0] FN_JR   = 6'd8;
  localparam logic [5:0] FN_NOP  = 6'd0;
  localparam logic [5:0] FN_DIVU = 6'd27;
  localparam logic [5:0] FN_MFHI = 6'd16;
  localparam logic [5:0] FN_MFLO = 6'd18;

  localparam int CLS_W   = 5;
  localparam int NUM_CLS = 17;

  localparam logic [CLS_W-1:0] CLS_ADD     = 5'd0;
  localparam logic [CLS_W-1:0] CLS_SUB     = 5'd1;
  localparam logic [CLS_W-1:0] CLS_AND     = 5'd2;
  localparam logic [CLS_W-1:0] CLS_OR      = 5'd3;
  localparam logic [CLS_W-1:0] CLS_SRL     = 5'd4;
  localparam logic [CLS_W-1:0] CLS_SLT     = 5'd5;
  localparam logic [CLS_W-1:0] CLS_JR      = 5'd6;
  localparam logic [CLS_W-1:0] CLS_NOP     = 5'd7;
  localparam logic [CLS_W-1:0] CLS_DIVU    = 5'd8;
  localparam logic [CLS_W-1:0] CLS_MFHI    = 5'd9;
  localparam logic [CLS_W-1:0] CLS_MFLO    = 5'd10;
  localparam logic [CLS_W-1:0] CLS_LW      = 5'd11;
  localparam logic [CLS_W-1:0] CLS_SW      = 5'd12;
  localparam logic [CLS_W-1:0] CLS_ORI     = 5'd13;
  localparam logic [CLS_W-1:0] CLS_BEQ     = 5'd14;
  localparam logic [CLS_W-1:0] CLS_J       = 5'd15;
  localparam logic [CLS_W-1:0] CLS_UNKNOWN = 5'd16;

  function automatic logic [CLS_W-1:0] classify(input logic [5:0] opcode,
                                                input logic [5:0] funct);
    logic [CLS_W-1:0] cls;
    cls = CLS_UNKNOWN;
    if (opcode == OP_RTYPE) begin
      case (funct)
        FN_ADD:  cls = CLS_ADD;
        FN_SUB:  cls = CLS_SUB;
        FN_AND:  cls = CLS_AND;
        FN_OR:   cls = CLS_OR;
        FN_SRL:  cls = CLS_SRL;
        FN_SLT:  cls = CLS_SLT;
        FN_JR:   cls = CLS_JR;
        FN_NOP:  cls = CLS_NOP;
        FN_DIVU: cls = CLS_DIVU;
        FN_MFHI: cls = CLS_MFHI;
        FN_MFLO: cls = CLS_MFLO;
        default: cls = CLS_UNKNOWN;
      endcase
    end else begin
      case (opcode)
        OP_LW:   cls = CLS_LW;
        OP_SW:   cls = CLS_SW;
        OP_ORI:  cls = CLS_ORI;
        OP_BEQ:  cls = CLS_BEQ;
        OP_J:    cls = CLS_J;
        default: cls = CLS_UNKNOWN;
      endcase
    end
    return cls;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Show-ahead trace record FIFO with drop-new or overwrite-oldest behaviour
// when full, plus sticky overflow flag and saturating loss counter.
module trace_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int CNT_W    = 16,
  parameter int OVR_MODE = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     ready,
  input  logic [WIDTH-1:0]         wdata,
  output logic                     valid,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             wr_en;
  logic             full;
  logic             pop;

  assign level    = wr_q - rd_q;
  assign valid    = (level != '0);
  assign full     = (level == (AW+1)'(DEPTH));
  assign pop      = valid && ready;
  assign overflow = ovf_q;
  assign drop_cnt = drop_q;
  assign rdata    = valid ? mem_q[rd_q[AW-1:0]] : '0;

  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    ovf_d  = ovf_q;
    drop_d = drop_q;
    wr_en  = 1'b0;
    if (clr) begin
      wr_d   = '0;
      rd_d   = '0;
      ovf_d  = 1'b0;
      drop_d = '0;
    end else begin
      if (pop) rd_d = rd_q + (AW+1)'(1);
      if (push) begin
        if (!full || pop) begin
          wr_en = 1'b1;
        end else begin
          // Full with no pop: the record is lost either way, only which one differs.
          ovf_d = 1'b1;
          if (drop_q != '1) drop_d = drop_q + CNT_W'(1);
          if (OVR_MODE != 0) begin
            wr_en = 1'b1;
            rd_d  = rd_q + (AW+1)'(1);
          end
        end
      end
      if (wr_en) wr_d = wr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      ovf_q  <= ovf_d;
      drop_q <= drop_d;
    end
  end

  // Record storage carries data only; emptiness comes from the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/instr_trace_unit.sv
// Retirement tracer: classifies retiring instructions, keeps per-class event
// counters and buffers cycle-stamped records in a trace FIFO.
module instr_trace_unit
  import trace_pkg::*;
#(
  parameter int PC_W     = 32,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 16,
  parameter int STAMP_W  = 16,
  parameter int CNT_W    = 16,
  parameter int OVR_MODE = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   clr,
  input  logic                   ret_valid,
  input  logic [PC_W-1:0]        ret_pc,
  input  logic [5:0]             ret_opcode,
  input  logic [5:0]             ret_funct,
  input  logic [DATA_W-1:0]      ret_wd,
  output logic                   tr_valid,
  input  logic                   tr_ready,
  output logic [PC_W-1:0]        tr_pc,
  output logic [4:0]             tr_class,
  output logic [DATA_W-1:0]      tr_wd,
  output logic [STAMP_W-1:0]     tr_stamp,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [CNT_W-1:0]       drop_cnt,
  input  logic [4:0]             cnt_sel,
  output logic [CNT_W-1:0]       cnt_val
);

  localparam int REC_W = STAMP_W + PC_W + CLS_W + DATA_W;

  logic [STAMP_W-1:0] stamp_q, stamp_d;
  logic [CLS_W-1:0]   cls;
  logic               push;
  logic [REC_W-1:0]   rec_in, rec_out;
  logic [CNT_W-1:0]   cnt_q [NUM_CLS];
  logic [CNT_W-1:0]   cnt_d [NUM_CLS];

  assign cls     = classify(ret_opcode, ret_funct);
  assign push    = en && ret_valid;
  assign stamp_d = stamp_q + STAMP_W'(1);
  assign rec_in  = {stamp_q, ret_pc, cls, ret_wd};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stamp_q <= '0;
    else      stamp_q <= stamp_d;
  end

  // Class counters advance on every push, including ones the FIFO later drops.
  always_comb begin
    for (int k = 0; k < NUM_CLS; k++) cnt_d[k] = cnt_q[k];
    if (clr) begin
      for (int k = 0; k < NUM_CLS; k++) cnt_d[k] = '0;
    end else if (push && (cnt_q[cls] != '1)) begin
      cnt_d[cls] = cnt_q[cls] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_CLS; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_CLS; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  always_comb begin
    cnt_val = '0;
    if (cnt_sel < CLS_W'(NUM_CLS)) cnt_val = cnt_q[cnt_sel];
  end

  trace_fifo #(
    .WIDTH    (REC_W),
    .DEPTH    (DEPTH),
    .CNT_W    (CNT_W),
    .OVR_MODE (OVR_MODE)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .push     (push),
    .ready    (tr_ready),
    .wdata    (rec_in),
    .valid    (tr_valid),
    .rdata    (rec_out),
    .level    (level),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  assign {tr_stamp, tr_pc, tr_class, tr_wd} = rec_out;

endmodule

// File: tb/tb_instr_trace_unit.sv
// Bench for instr_trace_unit: one 16-deep instance and two 4-deep instances
// (drop-new and overwrite-oldest) driven in parallel against a queue model.
`timescale 1ns/1ps
module tb_instr_trace_unit;

  typedef struct {
    int          stamp;
    logic [31:0] pc;
    int          cls;
    logic [31:0] wd;
  } rec_t;

  logic        clk, rst, en, clr, ret_valid, tr_ready;
  logic [31:0] ret_pc, ret_wd;
  logic [5:0]  ret_opcode, ret_funct;
  logic [4:0]  cnt_sel;

  logic        v0, v1, v2, ov0, ov1, ov2;
  logic [31:0] pc0, pc1, pc2, wd0, wd1, wd2;
  logic [4:0]  cls0, cls1, cls2;
  logic [15:0] st0, dr0, cv0;
  logic [3:0]  st1, st2;
  logic [4:0]  lv0;
  logic [2:0]  lv1, lv2, dr1, dr2, cv1, cv2;

  int n_cmp = 0;
  int n_err = 0;

  rec_t mq [3][$];
  int   mdrop [3];
  bit   movf [3];
  int   mcnt [3][17];
  int   cap [3]   = '{65535, 7, 7};
  int   smask [3] = '{16'hffff, 4'hf, 4'hf};
  int   depth [3] = '{16, 4, 4};
  bit   omode [3] = '{1'b0, 1'b0, 1'b1};
  int   mstamp;
  int   fn_map [int];
  int   op_map [int];

  instr_trace_unit #(.DEPTH(16), .STAMP_W(16), .CNT_W(16), .OVR_MODE(0)) u_main (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .ret_valid(ret_valid), .ret_pc(ret_pc),
    .ret_opcode(ret_opcode), .ret_funct(ret_funct), .ret_wd(ret_wd), .tr_valid(v0),
    .tr_ready(tr_ready), .tr_pc(pc0), .tr_class(cls0), .tr_wd(wd0), .tr_stamp(st0),
    .level(lv0), .overflow(ov0), .drop_cnt(dr0), .cnt_sel(cnt_sel), .cnt_val(cv0));

  instr_trace_unit #(.DEPTH(4), .STAMP_W(4), .CNT_W(3), .OVR_MODE(0)) u_drop (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .ret_valid(ret_valid), .ret_pc(ret_pc),
    .ret_opcode(ret_opcode), .ret_funct(ret_funct), .ret_wd(ret_wd), .tr_valid(v1),
    .tr_ready(tr_ready), .tr_pc(pc1), .tr_class(cls1), .tr_wd(wd1), .tr_stamp(st1),
    .level(lv1), .overflow(ov1), .drop_cnt(dr1), .cnt_sel(cnt_sel), .cnt_val(cv1));

  instr_trace_unit #(.DEPTH(4), .STAMP_W(4), .CNT_W(3), .OVR_MODE(1)) u_ovr (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .ret_valid(ret_valid), .ret_pc(ret_pc),
    .ret_opcode(ret_opcode), .ret_funct(ret_funct), .ret_wd(ret_wd), .tr_valid(v2),
    .tr_ready(tr_ready), .tr_pc(pc2), .tr_class(cls2), .tr_wd(wd2), .tr_stamp(st2),
    .level(lv2), .overflow(ov2), .drop_cnt(dr2), .cnt_sel(cnt_sel), .cnt_val(cv2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_class(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'd0) return fn_map.exists(int'(fn)) ? fn_map[int'(fn)] : 16;
    return op_map.exists(int'(op)) ? op_map[int'(op)] : 16;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mq[i].delete();
      mdrop[i] = 0;
      movf[i]  = 1'b0;
      for (int k = 0; k < 17; k++) mcnt[i][k] = 0;
    end
    mstamp = 0;
  endtask

  task automatic check_inst(input int i, input logic tv, input logic [31:0] pc,
                            input logic [4:0] cls, input logic [31:0] wd,
                            input logic [15:0] st, input logic [15:0] lvl, input logic ovf,
                            input logic [15:0] drop, input logic [15:0] cv);
    int   sz;
    rec_t h;
    sz = mq[i].size();
    chk($sformatf("u%0d.tr_valid", i), 64'(tv), 64'(sz > 0));
    chk($sformatf("u%0d.level", i), 64'(lvl), 64'(sz));
    chk($sformatf("u%0d.overflow", i), 64'(ovf), 64'(movf[i]));
    chk($sformatf("u%0d.drop_cnt", i), 64'(drop), 64'(mdrop[i]));
    chk($sformatf("u%0d.cnt_val[%0d]", i, cnt_sel), 64'(cv),
        64'((cnt_sel < 17) ? mcnt[i][cnt_sel] : 0));
    if (sz > 0) begin
      h = mq[i][0];
      chk($sformatf("u%0d.tr_pc", i), 64'(pc), 64'(h.pc));
      chk($sformatf("u%0d.tr_class", i), 64'(cls), 64'(h.cls));
      chk($sformatf("u%0d.tr_wd", i), 64'(wd), 64'(h.wd));
      chk($sformatf("u%0d.tr_stamp", i), 64'(st), 64'(h.stamp & smask[i]));
    end
  endtask

  task automatic check_all();
    check_inst(0, v0, pc0, cls0, wd0, st0, 16'(lv0), ov0, dr0, cv0);
    check_inst(1, v1, pc1, cls1, wd1, 16'(st1), 16'(lv1), ov1, 16'(dr1), 16'(cv1));
    check_inst(2, v2, pc2, cls2, wd2, 16'(st2), 16'(lv2), ov2, 16'(dr2), 16'(cv2));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".v0"}, 64'(v0), 64'd0);   chk({tag, ".pc0"}, 64'(pc0), 64'd0);
    chk({tag, ".cls0"}, 64'(cls0), 64'd0); chk({tag, ".wd0"}, 64'(wd0), 64'd0);
    chk({tag, ".st0"}, 64'(st0), 64'd0); chk({tag, ".lv0"}, 64'(lv0), 64'd0);
    chk({tag, ".ov0"}, 64'(ov0), 64'd0); chk({tag, ".dr0"}, 64'(dr0), 64'd0);
    chk({tag, ".cv0"}, 64'(cv0), 64'd0);
    chk({tag, ".v1"}, 64'(v1), 64'd0);   chk({tag, ".lv1"}, 64'(lv1), 64'd0);
    chk({tag, ".dr1"}, 64'(dr1), 64'd0); chk({tag, ".pc1"}, 64'(pc1), 64'd0);
    chk({tag, ".v2"}, 64'(v2), 64'd0);   chk({tag, ".lv2"}, 64'(lv2), 64'd0);
    chk({tag, ".ov2"}, 64'(ov2), 64'd0); chk({tag, ".st2"}, 64'(st2), 64'd0);
  endtask

  // Apply the spec's rules to the model with the inputs as they stand before
  // the edge, clock once, then compare every instance.
  task automatic step();
    int   c, sz;
    bit   push, pop;
    rec_t r;
    push    = en && ret_valid;
    c       = ref_class(ret_opcode, ret_funct);
    r.stamp = mstamp;
    r.pc    = ret_pc;
    r.cls   = c;
    r.wd    = ret_wd;
    for (int i = 0; i < 3; i++) begin
      if (clr) begin
        mq[i].delete();
        mdrop[i] = 0;
        movf[i]  = 1'b0;
        for (int k = 0; k < 17; k++) mcnt[i][k] = 0;
      end else begin
        sz  = mq[i].size();
        pop = (sz > 0) && tr_ready;
        if (push && mcnt[i][c] < cap[i]) mcnt[i][c]++;
        if (pop) void'(mq[i].pop_front());
        if (push) begin
          if (sz < depth[i] || pop) begin
            mq[i].push_back(r);
          end else begin
            movf[i] = 1'b1;
            if (mdrop[i] < cap[i]) mdrop[i]++;
            if (omode[i]) begin
              void'(mq[i].pop_front());
              mq[i].push_back(r);
            end
          end
        end
      end
    end
    @(posedge clk);
    mstamp++;
    #1;
    check_all();
  endtask

  task automatic drive(input bit p, input logic [5:0] op, input logic [5:0] fn,
                       input logic [31:0] pc, input logic [31:0] wd, input bit rdy,
                       input bit c);
    en = 1'b1; ret_valid = p; ret_opcode = op; ret_funct = fn;
    ret_pc = pc; ret_wd = wd; tr_ready = rdy; clr = c;
    step();
  endtask

  int ops [9] = '{0, 0, 0, 35, 43, 13, 4, 2, 63};
  int fns [12] = '{32, 34, 36, 37, 2, 42, 8, 0, 27, 16, 18, 5};
  int exp_cls [5] = '{11, 12, 14, 15, 16};
  int exp_op [5]  = '{35, 43, 4, 2, 63};

  initial begin
    fn_map[32] = 0; fn_map[34] = 1; fn_map[36] = 2; fn_map[37] = 3; fn_map[2] = 4;
    fn_map[42] = 5; fn_map[8] = 6;  fn_map[0] = 7;  fn_map[27] = 8; fn_map[16] = 9;
    fn_map[18] = 10;
    op_map[35] = 11; op_map[43] = 12; op_map[13] = 13; op_map[4] = 14; op_map[2] = 15;
    model_reset();

    rst = 1'b0; en = 1'b0; clr = 1'b0; ret_valid = 1'b0; tr_ready = 1'b0;
    ret_pc = '0; ret_wd = '0; ret_opcode = '0; ret_funct = '0; cnt_sel = '0;
    #1;
    chk_zero("reset");
    #1 rst = 1'b1;

    for (int k = 0; k < 3; k++) drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 6'd0, 6'd32, 32'h4, 32'd7, 0, 0);
    chk("add.tr_valid", 64'(v0), 64'd1);
    chk("add.tr_class", 64'(cls0), 64'd0);
    chk("add.tr_pc", 64'(pc0), 64'h4);
    chk("add.tr_wd", 64'(wd0), 64'd7);
    chk("add.tr_stamp", 64'(st0), 64'd3);
    chk("add.cnt_val", 64'(cv0), 64'd1);
    drive(0, 0, 0, 0, 0, 1, 0);
    chk("add.popped", 64'(v0), 64'd0);

    for (int k = 0; k < 5; k++)
      drive(1, 6'(exp_op[k]), 6'd0, 32'h100 + 32'(4 * k), 32'h50 + 32'(k), 0, 0);
    chk("five.level", 64'(lv0), 64'd5);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("five.class%0d", k), 64'(cls0), 64'(exp_cls[k]));
      cnt_sel = 5'(exp_cls[k]);
      drive(0, 0, 0, 0, 0, 1, 0);
      chk($sformatf("five.cnt%0d", exp_cls[k]), 64'(cv0), 64'd1);
    end

    drive(0, 0, 0, 0, 0, 0, 1);
    cnt_sel = 5'd0;
    for (int k = 1; k <= 6; k++) drive(1, 6'd0, 6'd32, 32'(k), 32'(k * 3), 0, 0);
    chk("d4m0.level", 64'(lv1), 64'd4);
    chk("d4m0.drop", 64'(dr1), 64'd2);
    chk("d4m0.ovf", 64'(ov1), 64'd1);
    chk("d4m0.head", 64'(pc1), 64'd1);
    chk("d4m1.level", 64'(lv2), 64'd4);
    chk("d4m1.drop", 64'(dr2), 64'd2);
    chk("d4m1.ovf", 64'(ov2), 64'd1);
    chk("d4m1.head", 64'(pc2), 64'd3);
    drive(1, 6'd0, 6'd32, 32'd7, 32'd21, 1, 0);
    chk("full_pp.m0.level", 64'(lv1), 64'd4);
    chk("full_pp.m0.drop", 64'(dr1), 64'd2);
    chk("full_pp.m0.head", 64'(pc1), 64'd2);
    chk("full_pp.m1.level", 64'(lv2), 64'd4);
    chk("full_pp.m1.drop", 64'(dr2), 64'd2);
    chk("full_pp.m1.head", 64'(pc2), 64'd4);

    drive(1, 6'd35, 6'd0, 32'h200, 32'h9, 1, 1);
    chk("clr.level", 64'(lv0), 64'd0);
    chk("clr.cnt_add", 64'(cv0), 64'd0);
    chk("clr.ovf", 64'(ov1), 64'd0);
    drive(1, 6'd13, 6'd0, 32'h204, 32'hA, 0, 0);

    for (int n = 0; n < 400; n++) begin
      int r;
      en         = ($urandom_range(0, 9) != 0);
      ret_valid  = ($urandom_range(0, 3) != 0);
      r          = $urandom_range(0, 9);
      ret_opcode = (r < 9) ? 6'(ops[r]) : 6'($urandom_range(0, 63));
      ret_funct  = 6'(fns[$urandom_range(0, 11)]);
      ret_pc     = $urandom;
      ret_wd     = $urandom;
      tr_ready   = ($urandom_range(0, 9) < 3);
      clr        = ($urandom_range(0, 59) == 0);
      cnt_sel    = 5'($urandom_range(0, 31));
      step();
    end

    for (int k = 0; k < 3; k++) drive(1, 6'd43, 6'd0, 32'(k), 32'(k), 0, 0);
    drive(1, 6'd4, 6'd0, 32'h300, 32'h1, 1, 0);
    cnt_sel = 5'd12;
    #3 rst = 1'b0;
    #1;
    model_reset();
    chk_zero("midrst");
    #1 rst = 1'b1;
    en = 1'b0;
    step();
    for (int k = 0; k < 4; k++) drive(1, 6'd0, 6'(fns[k]), 32'(k), 32'(k), k[0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_trace_unit.md
Name: instr_trace_unit

Overview:
- Synthesizable in-design retirement tracer for the mips_pipeline core. It replaces ad-hoc $display decoding with a hardware monitor.
- Classifies each retired instruction by opcode/funct into a fixed class code.
- Keeps one saturating event counter per class.
- Time-stamps and buffers retirement records in a parametrised trace FIFO, read out through a valid/ready handshake.
- Sits beside the CPU, fed from the writeback-stage signals.

Parameters:
PC_W, 32, width of retired PC field
DATA_W, 32, width of writeback data field
DEPTH, 16, trace FIFO entries (power of two, >=2)
STAMP_W, 16, cycle-stamp width (wraps)
CNT_W, 16, width of per-class and drop counters (saturating)
OVR_MODE, 0, 0 = drop new record when full; 1 = overwrite oldest record

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
en  in  1  trace enable; when 0, no captures and no counter updates
clr  in  1  synchronous clear of FIFO, class counters, overflow, drop_cnt
ret_valid  in  1  an instruction retires this cycle
ret_pc  in  PC_W  PC of retiring instruction
ret_opcode  in  6  opcode field
ret_funct  in  6  funct field
ret_wd  in  DATA_W  register-file write data
tr_valid  out  1  head record available
tr_ready  in  1  consumer accepts head record
tr_pc  out  PC_W  head record PC
tr_class  out  5  head record class code
tr_wd  out  DATA_W  head record write data
tr_stamp  out  STAMP_W  head record cycle stamp
level  out  $clog2(DEPTH)+1  FIFO occupancy
overflow  out  1  sticky: a record was dropped or overwritten
drop_cnt  out  CNT_W  number of lost records, saturating
cnt_sel  in  5  class counter select
cnt_val  out  CNT_W  counter of class cnt_sel, combinational; 0 if cnt_sel>16

Behaviour:
- Reset (rst=0, async): all outputs 0; FIFO empty; stamp=0; all counters, overflow and drop_cnt = 0.
- Stamp: free-running; increments every clk after reset release and wraps at 2^STAMP_W. clr does not affect it.
- Class codes when opcode==0, by funct:
  - 32 ADD=0, 34 SUB=1, 36 AND=2, 37 OR=3, 2 SRL=4, 42 SLT=5, 8 JR=6, 0 NOP=7, 27 DIVU=8, 16 MFHI=9, 18 MFLO=10.
  - Any other funct maps to 16 (UNKNOWN).
- Class codes when opcode!=0: 35 LW=11, 43 SW=12, 13 ORI=13, 4 BEQ=14, 2 J=15; anything else 16.
- Capture: a push occurs on the edge where en=1 && ret_valid=1. The record is {stamp, ret_pc, class, ret_wd}.
- Counter update: on a push, counter[class] increments and holds at 2^CNT_W-1.
- Latency: a record pushed into an empty FIFO drives tr_valid=1 on the following cycle. There is no same-cycle bypass.
- FIFO is show-ahead: tr_* reflect the head whenever tr_valid=1. Pop occurs when tr_valid && tr_ready.
- tr_* are held stable while tr_valid=1 and tr_ready=0.
- Full with OVR_MODE=0:
  - Push without a simultaneous pop: record discarded; overflow<=1; drop_cnt++ (saturating).
  - Push with a simultaneous pop: record accepted; level unchanged.
- Full with OVR_MODE=1:
  - Push overwrites the oldest entry; rd pointer advances; overflow<=1; drop_cnt++.
  - Push with a simultaneous pop: normal pop+push, no loss.
- Empty with tr_ready=1: no pop; level stays 0.
- Pointers wrap modulo DEPTH. level = wr_cnt - rd_cnt, carried in $clog2(DEPTH)+1 bits.
- clr=1 has priority over push and pop in the same cycle. The coincident record is neither stored nor counted. The FIFO empties the next cycle.
- Reset asserted mid-transfer discards everything immediately, regardless of handshake state.

Decomposition:
- Package trace_pkg holds:
  - opcode/funct localparams (OP_RTYPE, OP_LW, OP_SW, OP_ORI, OP_BEQ, OP_J, FN_*);
  - class code constants CLS_ADD..CLS_UNKNOWN (5-bit), NUM_CLS=17;
  - a classify function.
- Sub-module trace_fifo holds the FIFO: parametrised width/depth, OVR_MODE handling, level and drop signalling.
- The top module holds the stamp counter, classifier, and class counter bank.

Test Plan:
- Reset then push ADD (op 0, fn 32, pc 0x04, wd 7) at stamp 3 -> next cycle tr_valid=1, tr_class=0, tr_pc=0x04, tr_wd=7, tr_stamp=3; cnt_sel=0 gives cnt_val=1.
- Push LW, SW, BEQ, J, op 63 on consecutive cycles with tr_ready=0 -> classes 11, 12, 14, 15, 16 read back in order; level=5; each class counter =1.
- DEPTH=4, OVR_MODE=0, 6 pushes with tr_ready=0 -> level=4; first 4 records retained; drop_cnt=2; overflow=1.
- DEPTH=4, OVR_MODE=1, same stimulus -> records 3..6 retained; drop_cnt=2; overflow=1.
- Full FIFO, push and tr_ready=1 together (both modes) -> level stays 4; drop_cnt unchanged.
- clr with a coincident push, then rst pulsed low mid-read -> after clr, level=0, counters 0, stamp still running; after rst, all outputs 0 asynchronously.
